instr_fetch_decode: RTL and testbench

- Front-end stage of the PDP-8 pipeline. Sits directly upstream of the EXEC unit.
- Fetches the instruction word at the current PC from memory_pdp. Decodes it into pdp_mem_opcode_s / pdp_op7_opcode_s and resolves the effective address, including indirect and auto-index pointers.
- Holds the decoded instruction stable until EXEC finishes, indicated by a stall/unstall handshake. Then takes the retired PC from EXEC and fetches the next instruction.

---
 rtl/pdp8_pkg.sv | 88 ++++++++
 rtl/instr_fetch_decode_op_decoder.sv | 52 +++++
 rtl/instr_fetch_decode.sv | 150 +++++++++++++++
 tb/tb_instr_fetch_decode.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types and constants for the fetch/decode front end.
package pdp8_pkg;

    localparam int unsigned ADDR_WIDTH = 12;
    localparam int unsigned DATA_WIDTH = 12;

    localparam logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200;
    localparam logic [ADDR_WIDTH-1:0] AUTOIDX_LO    = 12'o0010;
    localparam logic [ADDR_WIDTH-1:0] AUTOIDX_HI    = 12'o0017;

    // Group-7 operate microinstruction words (exact-match decode)
    localparam logic [DATA_WIDTH-1:0] OP7_NOP     = 12'o7000;
    localparam logic [DATA_WIDTH-1:0] OP7_IAC     = 12'o7001;
    localparam logic [DATA_WIDTH-1:0] OP7_RAL     = 12'o7004;
    localparam logic [DATA_WIDTH-1:0] OP7_RTL     = 12'o7006;
    localparam logic [DATA_WIDTH-1:0] OP7_RAR     = 12'o7010;
    localparam logic [DATA_WIDTH-1:0] OP7_RTR     = 12'o7012;
    localparam logic [DATA_WIDTH-1:0] OP7_CML     = 12'o7020;
    localparam logic [DATA_WIDTH-1:0] OP7_CMA     = 12'o7040;
    localparam logic [DATA_WIDTH-1:0] OP7_CIA     = 12'o7041;
    localparam logic [DATA_WIDTH-1:0] OP7_CLL     = 12'o7100;
    localparam logic [DATA_WIDTH-1:0] OP7_CLA1    = 12'o7200;
    localparam logic [DATA_WIDTH-1:0] OP7_CLA_CLL = 12'o7300;
    localparam logic [DATA_WIDTH-1:0] OP7_HLT     = 12'o7402;
    localparam logic [DATA_WIDTH-1:0] OP7_OSR     = 12'o7404;
    localparam logic [DATA_WIDTH-1:0] OP7_SKP     = 12'o7410;
    localparam logic [DATA_WIDTH-1:0] OP7_SNL     = 12'o7420;
    localparam logic [DATA_WIDTH-1:0] OP7_SZL     = 12'o7430;
    localparam logic [DATA_WIDTH-1:0] OP7_SZA     = 12'o7440;
    localparam logic [DATA_WIDTH-1:0] OP7_SNA     = 12'o7450;
    localparam logic [DATA_WIDTH-1:0] OP7_SMA     = 12'o7500;
    localparam logic [DATA_WIDTH-1:0] OP7_SPA     = 12'o7510;
    localparam logic [DATA_WIDTH-1:0] OP7_CLA2    = 12'o7600;

    typedef enum logic [2:0] {
        FETCH,
        FETCH_WAIT,
        DECODE,
        IND_RD,
        IND_WAIT,
        AUTOINC,
        ISSUE,
        EXEC_WAIT
    } ifd_state_e;

    // Memory-reference instruction: one-hot op plus effective address
    typedef struct packed {
        logic                  AND;
        logic                  TAD;
        logic                  ISZ;
        logic                  DCA;
        logic                  JMS;
        logic                  JMP;
        logic [ADDR_WIDTH-1:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    // Group-7 operate microcode, one-hot
    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

    // Page-zero locations 0010..0017 auto-increment their pointer on indirect use
    function automatic logic is_autoidx(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= AUTOIDX_LO) && (addr <= AUTOIDX_HI);
    endfunction

endpackage

// File: rtl/instr_fetch_decode_op_decoder.sv
// Combinational instruction decoder: IR and resolved EA in, opcode structs out.
module op_decoder
    import pdp8_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic [ADDR_WIDTH-1:0] ea,
    output pdp_mem_opcode_s       mem_opcode_c,
    output pdp_op7_opcode_s       op7_opcode_c
);

    // Memory ops set one flag with EA; IOT and unknown operate words fall back to NOP
    always_comb begin
        mem_opcode_c = '0;
        op7_opcode_c = '0;
        case (ir[DATA_WIDTH-1 -: 3])
            3'd0: begin mem_opcode_c.AND = 1'b1; mem_opcode_c.mem_inst_addr = ea; end
            3'd1: begin mem_opcode_c.TAD = 1'b1; mem_opcode_c.mem_inst_addr = ea; end
            3'd2: begin mem_opcode_c.ISZ = 1'b1; mem_opcode_c.mem_inst_addr = ea; end
            3'd3: begin mem_opcode_c.DCA = 1'b1; mem_opcode_c.mem_inst_addr = ea; end
            3'd4: begin mem_opcode_c.JMS = 1'b1; mem_opcode_c.mem_inst_addr = ea; end
            3'd5: begin mem_opcode_c.JMP = 1'b1; mem_opcode_c.mem_inst_addr = ea; end
            3'd6: op7_opcode_c.NOP = 1'b1;
            default: begin
                case (ir)
                    OP7_IAC:     op7_opcode_c.IAC     = 1'b1;
                    OP7_RAL:     op7_opcode_c.RAL     = 1'b1;
                    OP7_RTL:     op7_opcode_c.RTL     = 1'b1;
                    OP7_RAR:     op7_opcode_c.RAR     = 1'b1;
                    OP7_RTR:     op7_opcode_c.RTR     = 1'b1;
                    OP7_CML:     op7_opcode_c.CML     = 1'b1;
                    OP7_CMA:     op7_opcode_c.CMA     = 1'b1;
                    OP7_CIA:     op7_opcode_c.CIA     = 1'b1;
                    OP7_CLL:     op7_opcode_c.CLL     = 1'b1;
                    OP7_CLA1:    op7_opcode_c.CLA1    = 1'b1;
                    OP7_CLA_CLL: op7_opcode_c.CLA_CLL = 1'b1;
                    OP7_HLT:     op7_opcode_c.HLT     = 1'b1;
                    OP7_OSR:     op7_opcode_c.OSR     = 1'b1;
                    OP7_SKP:     op7_opcode_c.SKP     = 1'b1;
                    OP7_SNL:     op7_opcode_c.SNL     = 1'b1;
                    OP7_SZL:     op7_opcode_c.SZL     = 1'b1;
                    OP7_SZA:     op7_opcode_c.SZA     = 1'b1;
                    OP7_SNA:     op7_opcode_c.SNA     = 1'b1;
                    OP7_SMA:     op7_opcode_c.SMA     = 1'b1;
                    OP7_SPA:     op7_opcode_c.SPA     = 1'b1;
                    OP7_CLA2:    op7_opcode_c.CLA2    = 1'b1;
                    default:     op7_opcode_c.NOP     = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// PDP-8 fetch/decode stage: fetches at PC, resolves EA (incl. indirect and
// auto-index), holds the decoded op until EXEC retires it via stall.
module instr_fetch_decode
    import pdp8_pkg::*;
#(
    parameter int unsigned           ADDR_W     = ADDR_WIDTH,
    parameter int unsigned           DATA_W     = DATA_WIDTH,
    parameter logic [ADDR_W-1:0]     START_ADDR = START_ADDRESS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic [ADDR_W-1:0]    PC_value,
    output logic                 ifu_rd_req,
    output logic [ADDR_W-1:0]    ifu_rd_addr,
    input  logic [DATA_W-1:0]    ifu_rd_data,
    output logic                 ifu_wr_req,
    output logic [ADDR_W-1:0]    ifu_wr_addr,
    output logic [DATA_W-1:0]    ifu_wr_data,
    output logic [ADDR_W-1:0]    base_addr,
    output pdp_mem_opcode_s      pdp_mem_opcode,
    output pdp_op7_opcode_s      pdp_op7_opcode
);

    ifd_state_e        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ea;

    logic              mem_ref_c;
    logic              indirect_c;
    logic [ADDR_W-1:0] ea_direct_c;
    logic [DATA_W-1:0] ptr_inc_c;
    logic [ADDR_W-1:0] dec_ea_c;
    pdp_mem_opcode_s   dec_mem_c;
    pdp_op7_opcode_s   dec_op7_c;

    // Instruction fields and direct (page-zero or current-page) effective address
    always_comb begin
        mem_ref_c   = (ir[DATA_W-1 -: 3] <= 3'd5);
        indirect_c  = ir[DATA_W-4];
        ea_direct_c = ir[DATA_W-5] ? {pc[ADDR_W-1:7], ir[6:0]} : ADDR_W'(ir[6:0]);
        ptr_inc_c   = ifu_rd_data + DATA_W'(1);
    end

    // EA presented to the decoder on the cycle the structs are loaded
    always_comb begin
        dec_ea_c = ea;
        case (state)
            DECODE:   dec_ea_c = ea_direct_c;
            IND_WAIT: dec_ea_c = ADDR_W'(ifu_rd_data);
            AUTOINC:  dec_ea_c = ADDR_W'(ifu_wr_data);
            default:  dec_ea_c = ea;
        endcase
    end

    op_decoder u_op_decoder (
        .ir           (ir),
        .ea           (dec_ea_c),
        .mem_opcode_c (dec_mem_c),
        .op7_opcode_c (dec_op7_c)
    );

    // Sequencer; request outputs are registered and set on entry to the requesting
    // state. Out of reset FETCH spends one cycle raising its request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= FETCH;
            pc             <= START_ADDR;
            ir             <= '0;
            ea             <= '0;
            ifu_rd_req     <= 1'b0;
            ifu_rd_addr    <= '0;
            ifu_wr_req     <= 1'b0;
            ifu_wr_addr    <= '0;
            ifu_wr_data    <= '0;
            base_addr      <= START_ADDR;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
        end else begin
            base_addr <= START_ADDR;
            case (state)
                FETCH: begin
                    if (ifu_rd_req) begin
                        ifu_rd_req <= 1'b0;
                        state      <= FETCH_WAIT;
                    end else begin
                        ifu_rd_req  <= 1'b1;
                        ifu_rd_addr <= pc;
                    end
                end
                FETCH_WAIT: begin
                    ir    <= ifu_rd_data;
                    state <= DECODE;
                end
                DECODE: begin
                    ea <= ea_direct_c;
                    if (mem_ref_c && indirect_c) begin
                        ifu_rd_req  <= 1'b1;
                        ifu_rd_addr <= ea_direct_c;
                        state       <= IND_RD;
                    end else begin
                        pdp_mem_opcode <= dec_mem_c;
                        pdp_op7_opcode <= dec_op7_c;
                        state          <= ISSUE;
                    end
                end
                IND_RD: begin
                    ifu_rd_req <= 1'b0;
                    state      <= IND_WAIT;
                end
                IND_WAIT: begin
                    if (is_autoidx(ea)) begin
                        ifu_wr_req  <= 1'b1;
                        ifu_wr_addr <= ea;
                        ifu_wr_data <= ptr_inc_c;
                        state       <= AUTOINC;
                    end else begin
                        ea             <= ADDR_W'(ifu_rd_data);
                        pdp_mem_opcode <= dec_mem_c;
                        pdp_op7_opcode <= dec_op7_c;
                        state          <= ISSUE;
                    end
                end
                AUTOINC: begin
                    ifu_wr_req     <= 1'b0;
                    ea             <= ADDR_W'(ifu_wr_data);
                    pdp_mem_opcode <= dec_mem_c;
                    pdp_op7_opcode <= dec_op7_c;
                    state          <= ISSUE;
                end
                ISSUE: begin
                    if (stall) state <= EXEC_WAIT;
                end
                EXEC_WAIT: begin
                    if (!stall) begin
                        pc             <= PC_value;
                        ifu_rd_req     <= 1'b1;
                        ifu_rd_addr    <= PC_value;
                        pdp_mem_opcode <= '0;
                        pdp_op7_opcode <= '0;
                        state          <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomised self-checking bench for instr_fetch_decode with a memory model
// and an instruction-level reference model.
module tb_instr_fetch_decode;
    import pdp8_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            stall = 1'b0;
    logic [11:0]     PC_value = '0;
    logic            ifu_rd_req, ifu_wr_req;
    logic [11:0]     ifu_rd_addr, ifu_rd_data, ifu_wr_addr, ifu_wr_data, base_addr;
    pdp_mem_opcode_s mem_op;
    pdp_op7_opcode_s op7_op;

    int          vectors = 0;
    int          miscompares = 0;
    logic [11:0] mem [4096];
    logic [11:0] cur_pc;
    bit          pre;

    localparam logic [11:0] OP7_TAB [22] = '{
        12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020, 12'o7040,
        12'o7041, 12'o7100, 12'o7200, 12'o7300, 12'o7402, 12'o7404, 12'o7410, 12'o7420,
        12'o7430, 12'o7440, 12'o7450, 12'o7500, 12'o7510, 12'o7600};

    instr_fetch_decode dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .PC_value       (PC_value),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .ifu_rd_data    (ifu_rd_data),
        .ifu_wr_req     (ifu_wr_req),
        .ifu_wr_addr    (ifu_wr_addr),
        .ifu_wr_data    (ifu_wr_data),
        .base_addr      (base_addr),
        .pdp_mem_opcode (mem_op),
        .pdp_op7_opcode (op7_op)
    );

    always #5 clk = ~clk;

    // Memory read port: data valid the cycle after the request, garbage otherwise
    always @(posedge clk) begin
        if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];
        else            ifu_rd_data <= 12'($urandom);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: what one instruction at pc should do, from the ISA rules
    function automatic void model(input logic [11:0] pc, output int lat, output int nrd,
                                  output logic [11:0] rd2, output bit wr,
                                  output logic [11:0] wa, output logic [11:0] wd,
                                  output pdp_mem_opcode_s em, output pdp_op7_opcode_s eo);
        int w, op, ea, ptr, idx;
        bit ind, pg;
        w   = int'(mem[pc]);
        op  = w / 512;
        ind = ((w / 256) % 2) == 1;
        pg  = ((w / 128) % 2) == 1;
        ea  = pg ? (int'(pc) / 128) * 128 + (w % 128) : (w % 128);
        lat = 3; nrd = 1; rd2 = '0; wr = 1'b0; wa = '0; wd = '0; em = '0; eo = '0;
        if (op <= 5 && ind) begin
            nrd = 2;
            rd2 = 12'(ea);
            ptr = int'(mem[ea]);
            lat = 5;
            if (ea >= 8 && ea <= 15) begin
                wr  = 1'b1;
                wa  = 12'(ea);
                ea  = (ptr + 1) % 4096;
                wd  = 12'(ea);
                lat = 6;
            end else begin
                ea = ptr;
            end
        end
        if (op <= 5) begin
            em = pdp_mem_opcode_s'((18'(1) << (17 - op)) | 18'(ea));
        end else begin
            idx = 0;
            if (op == 7)
                for (int j = 0; j < 22; j++) if (OP7_TAB[j] == 12'(w)) idx = j;
            eo = pdp_op7_opcode_s'(22'(1) << (21 - idx));
        end
    endfunction

    function automatic logic [11:0] gen_word();
        int op;
        logic [11:0] w;
        op = int'($urandom_range(0, 7));
        if (op <= 5 && $urandom_range(0, 2) == 0)
            w = 12'(op * 512 + 256 + int'($urandom_range(8, 15)));
        else if (op == 7 && $urandom_range(0, 1) == 1)
            w = OP7_TAB[$urandom_range(0, 21)];
        else
            w = 12'(op * 512 + int'($urandom_range(0, 511)));
        return w;
    endfunction

    // Run the instruction at cur_pc, check it, hold stall, retire to next_pc
    task automatic exec_one(input bit early, input int stall_cyc, input logic [11:0] next_pc,
                            input string tag);
        int lat, nrd, k, nwr;
        bit ewr, found, both, stable;
        logic [11:0] rd2, wa, wd, got_wa, got_wd;
        logic [11:0] rds [$];
        pdp_mem_opcode_s em;
        pdp_op7_opcode_s eo;
        model(cur_pc, lat, nrd, rd2, ewr, wa, wd, em, eo);
        k = -1; nwr = 0; found = 0; both = 0; stable = 1; got_wa = '0; got_wd = '0;
        if (early) stall = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (!(c == 0 && pre)) @(negedge clk);
            if (ifu_rd_req && ifu_wr_req) both = 1;
            if (ifu_rd_req) begin rds.push_back(ifu_rd_addr); if (k < 0) k = 0; end
            if (ifu_wr_req) begin
                nwr++; got_wa = ifu_wr_addr; got_wd = ifu_wr_data;
                mem[ifu_wr_addr] = ifu_wr_data;
            end
            if (mem_op != '0 || op7_op != '0) begin found = 1; break; end
            if (k >= 0) k++;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s timeout: no opcode within 24 cycles (pc %o)", tag, cur_pc);
            stall = 1'b0; pre = 0; cur_pc = next_pc;
            return;
        end
        vectors++;
        if (k != lat) begin
            miscompares++; $display("FAIL %s latency: got %0d expected %0d", tag, k, lat);
        end
        vectors++;
        if (mem_op !== em) begin
            miscompares++; $display("FAIL %s mem_opcode: got %h expected %h", tag, mem_op, em);
        end
        vectors++;
        if (op7_op !== eo) begin
            miscompares++; $display("FAIL %s op7_opcode: got %h expected %h", tag, op7_op, eo);
        end
        vectors++;
        if (rds.size() != nrd || rds[0] !== cur_pc || (nrd == 2 && rds[1] !== rd2)) begin
            miscompares++;
            $display("FAIL %s reads: got %0d reads first %o expected %0d reads at %o,%o",
                     tag, rds.size(), (rds.size() > 0) ? rds[0] : 12'o0, nrd, cur_pc, rd2);
        end
        vectors++;
        if (nwr != int'(ewr) || (ewr && (got_wa !== wa || got_wd !== wd))) begin
            miscompares++;
            $display("FAIL %s write: got %0d writes %o<=%o expected %0d writes %o<=%o",
                     tag, nwr, got_wa, got_wd, int'(ewr), wa, wd);
        end
        vectors++;
        if (both) begin
            miscompares++; $display("FAIL %s req_overlap: got rd and wr together expected never", tag);
        end
        stall = 1'b1;
        for (int i = 0; i < stall_cyc; i++) begin
            PC_value = 12'($urandom);
            @(negedge clk);
            if (mem_op !== em || op7_op !== eo || ifu_rd_req || ifu_wr_req) stable = 0;
        end
        vectors++;
        if (!stable) begin
            miscompares++; $display("FAIL %s hold: got opcode change or request during stall expected stable", tag);
        end
        stall = 1'b0;
        PC_value = next_pc;
        @(negedge clk);
        PC_value = 12'($urandom);
        vectors++;
        if (mem_op !== '0 || op7_op !== '0 || ifu_rd_req !== 1'b1 || ifu_rd_addr !== next_pc) begin
            miscompares++;
            $display("FAIL %s retire: got mem %h op7 %h rd_req %b rd_addr %o expected zero structs, rd_req 1 at %o",
                     tag, mem_op, op7_op, ifu_rd_req, ifu_rd_addr, next_pc);
        end
        cur_pc = next_pc;
        pre = 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (ifu_rd_req !== 1'b0 || ifu_wr_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_req: got rd %b wr %b expected 0 0", ifu_rd_req, ifu_wr_req);
        end
        vectors++;
        if (mem_op !== '0 || op7_op !== '0) begin
            miscompares++; $display("FAIL reset_structs: got %h %h expected 0", mem_op, op7_op);
        end
        vectors++;
        if (base_addr !== 12'o0200) begin
            miscompares++; $display("FAIL reset_base: got %o expected 0200", base_addr);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (ifu_rd_req !== 1'b0 || mem_op !== '0 || base_addr !== 12'o0200) begin
            miscompares++;
            $display("FAIL reset_held: got rd %b mem %h base %o expected 0 0 0200", ifu_rd_req, mem_op, base_addr);
        end
        reset_n = 1'b1;
        cur_pc = 12'o0200;
        pre = 0;
    endtask

    task automatic test_direct();
        mem[12'o0200] = 12'o1205;
        exec_one(1'b0, 4, 12'o0300, "direct_tad");
    endtask

    task automatic test_indirect();
        mem[12'o0300] = 12'o3420;
        mem[12'o0020] = 12'o0500;
        exec_one(1'b0, 2, 12'o0200, "indirect_dca");
    endtask

    task automatic test_autoindex();
        mem[12'o0200] = 12'o1410;
        mem[12'o0010] = 12'o0777;
        exec_one(1'b0, 1, 12'o0200, "autoidx_tad");
        vectors++;
        if (mem[12'o0010] !== 12'o1000) begin
            miscompares++; $display("FAIL autoidx_mem: got %o expected 1000", mem[12'o0010]);
        end
        mem[12'o0200] = 12'o1410;
        mem[12'o0010] = 12'o7777;
        exec_one(1'b0, 2, 12'o7777, "autoidx_wrap");
    endtask

    task automatic test_page_wrap();
        mem[12'o7777] = 12'o5377;
        exec_one(1'b0, 1, 12'o7600, "page37_last");
        mem[12'o7600] = 12'o2600;
        exec_one(1'b0, 3, 12'o0200, "page37_first");
    endtask

    task automatic test_op7();
        mem[12'o0200] = 12'o7300;
        exec_one(1'b0, 2, 12'o0200, "op7_cla_cll");
        mem[12'o0200] = 12'o6001;
        exec_one(1'b0, 2, 12'o0200, "iot_nop");
        mem[12'o0200] = 12'o7777;
        exec_one(1'b1, 1, 12'o0200, "op7_unmatched_early_stall");
    endtask

    task automatic test_reset_mid(input bit at_autoinc);
        int seen;
        mem[cur_pc]   = 12'o1410;
        mem[12'o0010] = 12'($urandom);
        seen = pre ? 1 : 0;
        for (int c = 0; c < 12 && seen < 2; c++) begin
            @(negedge clk);
            if (ifu_rd_req) seen++;
        end
        @(negedge clk);
        if (at_autoinc) begin
            @(negedge clk);
            vectors++;
            if (ifu_wr_req !== 1'b1) begin
                miscompares++; $display("FAIL reset_mid_prewr: got wr_req %b expected 1", ifu_wr_req);
            end
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ifu_rd_req !== 1'b0 || ifu_wr_req !== 1'b0 || mem_op !== '0 || op7_op !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got rd %b wr %b mem %h op7 %h expected all 0",
                     ifu_rd_req, ifu_wr_req, mem_op, op7_op);
        end
        mem[12'o0200] = at_autoinc ? 12'o4123 : 12'o7040;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cur_pc = 12'o0200;
        pre = 0;
        exec_one(1'b0, 2, 12'o0200, "after_reset_mid");
    endtask

    task automatic test_random(input int n);
        logic [11:0] nxt;
        for (int i = 0; i < n; i++) begin
            mem[cur_pc] = gen_word();
            nxt = ($urandom_range(0, 3) == 0) ? 12'(12'o7600 + $urandom_range(0, 127)) : 12'($urandom);
            exec_one(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)), nxt, "random");
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 12'($urandom);
        test_reset();
        test_direct();
        test_indirect();
        test_autoindex();
        test_page_wrap();
        test_op7();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random(80);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
